// File: rtl/interconnect_pkg.sv
// interconnect_pkg
// Shared types and defaults for the interconnect blocks. Holds the state
// encoding and default sizing for the global-memory initialization sequencer.
package interconnect_pkg;

    // Sequencer states for global_mem_init_ctrl.
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        WRITE = 2'd1,
        READ  = 2'd2,
        DRAIN = 2'd3
    } init_ctrl_state_t;

    // Default burst length field width (word count minus one).
    localparam int unsigned INIT_LEN_L = 16;

    // Default read-return FIFO depth; must be a power of two, >= 2.
    localparam int unsigned INIT_RD_FIFO_DEPTH = 8;

endpackage

// File: rtl/init_rd_fifo.sv
// init_rd_fifo
// Synchronous FIFO buffering read returns from the interconnect until the host
// takes them. A pushed word is visible on pop_data in the following cycle.
// Push and pop may happen together, including when full or empty.
// Ports:
//   clk, rst         clock, asynchronous active-high reset (clears contents)
//   push, push_data  write side
//   pop, pop_data    read side; pop_data is the head word, valid when !empty
//   count            number of stored words
//   full, empty      status flags
module init_rd_fifo #(
    parameter int unsigned DEPTH = 8,
    parameter int unsigned WIDTH = 32
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       push,
    input  logic [WIDTH-1:0]           push_data,
    input  logic                       pop,
    output logic [WIDTH-1:0]           pop_data,
    output logic [$clog2(DEPTH+1)-1:0] count,
    output logic                       full,
    output logic                       empty
);

    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam int unsigned CNT_W = $clog2(DEPTH+1);
    localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic             push_ok;
    logic             pop_ok;

    assign full     = (count == DEPTH_C);
    assign empty    = (count == '0);
    assign pop_ok   = pop && !empty;
    // A full FIFO can still accept a word when the head leaves in the same cycle.
    assign push_ok  = push && (!full || pop_ok);
    assign pop_data = mem[rd_ptr];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push_ok) wr_ptr <= wr_ptr + 1'b1;
            if (pop_ok)  rd_ptr <= rd_ptr + 1'b1;
            case ({push_ok, pop_ok})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    // Storage needs no reset; the pointers define what is valid.
    always_ff @(posedge clk) begin
        if (push_ok) mem[wr_ptr] <= push_data;
    end

endmodule

// File: rtl/global_mem_init_ctrl.sv
// global_mem_init_ctrl
// Host-side sequencer for the global-memory initialization port. Runs write
// bursts (one stream word per beat) and read bursts (returns buffered in a
// FIFO with host back-pressure), one beat per cycle on init_mem_*.
// Ports:
//   clk, rst                         clock, asynchronous active-high reset
//   cmd_vld/cmd_rdy/cmd_wr/cmd_addr/cmd_len   burst command (len = words - 1)
//   wdata_vld/wdata_rdy/wdata        write stream in
//   rdata_vld/rdata_rdy/rdata        read stream out
//   init_mem_addr/vld/wr_en/wr_data  request side to interconnect
//   init_mem_rd_data/_vld            in-order read returns from interconnect
//   init_active                      high whenever a burst is in progress
//   done                             one-cycle pulse when a burst completes
//   err                              sticky flag for a return nobody asked for
module global_mem_init_ctrl
    import interconnect_pkg::*;
#(
    parameter int unsigned GLOBAL_MEM_ADDR_L = 16,
    parameter int unsigned DATA_L            = 32,
    parameter int unsigned LEN_L             = INIT_LEN_L,
    parameter int unsigned RD_FIFO_DEPTH     = INIT_RD_FIFO_DEPTH
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         cmd_vld,
    output logic                         cmd_rdy,
    input  logic                         cmd_wr,
    input  logic [GLOBAL_MEM_ADDR_L-1:0] cmd_addr,
    input  logic [LEN_L-1:0]             cmd_len,
    input  logic                         wdata_vld,
    output logic                         wdata_rdy,
    input  logic [DATA_L-1:0]            wdata,
    output logic                         rdata_vld,
    input  logic                         rdata_rdy,
    output logic [DATA_L-1:0]            rdata,
    output logic [GLOBAL_MEM_ADDR_L-1:0] init_mem_addr,
    output logic                         init_mem_vld,
    output logic                         init_mem_wr_en,
    output logic [DATA_L-1:0]            init_mem_wr_data,
    input  logic [DATA_L-1:0]            init_mem_rd_data,
    input  logic                         init_mem_rd_data_vld,
    output logic                         init_active,
    output logic                         done,
    output logic                         err
);

    localparam int unsigned CNT_W = $clog2(RD_FIFO_DEPTH+1);
    localparam logic [CNT_W:0] DEPTH_V = (CNT_W+1)'(RD_FIFO_DEPTH);

    init_ctrl_state_t             state;
    logic [GLOBAL_MEM_ADDR_L-1:0] base;
    logic [LEN_L-1:0]             len;
    logic [LEN_L-1:0]             k;
    logic [CNT_W-1:0]             outstanding;

    logic [CNT_W-1:0]             fifo_count;
    logic                         fifo_empty;
    logic                         fifo_full;
    logic                         unused_fifo_full;

    logic [GLOBAL_MEM_ADDR_L-1:0] beat_addr;
    logic                         last_beat;
    logic                         wr_beat;
    logic                         rd_issue;
    logic                         rd_ret_ok;
    logic                         rd_ret_bad;
    logic                         credit_ok;

    // cmd_rdy is gated by rst so it reads 0 for the whole reset pulse.
    assign cmd_rdy     = (state == IDLE) && !rst;
    assign wdata_rdy   = (state == WRITE);
    assign init_active = (state != IDLE);

    // Address wraps naturally at the width of the sum.
    assign beat_addr = base + GLOBAL_MEM_ADDR_L'(k);
    assign last_beat = (k == len);
    assign wr_beat   = (state == WRITE) && wdata_vld;

    // Every issued read is guaranteed a FIFO slot, so the FIFO never overflows.
    assign credit_ok = ({1'b0, outstanding} + {1'b0, fifo_count}) < DEPTH_V;
    assign rd_issue  = (state == READ) && credit_ok;

    assign rd_ret_ok  = init_mem_rd_data_vld && (outstanding != '0);
    assign rd_ret_bad = init_mem_rd_data_vld && (outstanding == '0);

    assign rdata_vld        = !fifo_empty;
    assign unused_fifo_full = fifo_full;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state            <= IDLE;
            base             <= '0;
            len              <= '0;
            k                <= '0;
            outstanding      <= '0;
            init_mem_addr    <= '0;
            init_mem_vld     <= 1'b0;
            init_mem_wr_en   <= 1'b0;
            init_mem_wr_data <= '0;
            done             <= 1'b0;
            err              <= 1'b0;
        end else begin
            done         <= 1'b0;
            init_mem_vld <= 1'b0;

            if (rd_ret_bad) err <= 1'b1;

            case ({rd_issue, rd_ret_ok})
                2'b10:   outstanding <= outstanding + 1'b1;
                2'b01:   outstanding <= outstanding - 1'b1;
                default: outstanding <= outstanding;
            endcase

            case (state)
                IDLE: begin
                    if (cmd_vld && cmd_rdy) begin
                        base  <= cmd_addr;
                        len   <= cmd_len;
                        k     <= '0;
                        state <= cmd_wr ? WRITE : READ;
                    end
                end
                WRITE: begin
                    if (wr_beat) begin
                        init_mem_vld     <= 1'b1;
                        init_mem_wr_en   <= 1'b1;
                        init_mem_addr    <= beat_addr;
                        init_mem_wr_data <= wdata;
                        if (last_beat) state <= DRAIN;
                        else           k     <= k + 1'b1;
                    end
                end
                READ: begin
                    if (rd_issue) begin
                        init_mem_vld   <= 1'b1;
                        init_mem_wr_en <= 1'b0;
                        init_mem_addr  <= beat_addr;
                        if (last_beat) state <= DRAIN;
                        else           k     <= k + 1'b1;
                    end
                end
                DRAIN: begin
                    // Write bursts have nothing outstanding and leave at once.
                    if (outstanding == '0) begin
                        done  <= 1'b1;
                        state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    init_rd_fifo #(
        .DEPTH (RD_FIFO_DEPTH),
        .WIDTH (DATA_L)
    ) u_rd_fifo (
        .clk       (clk),
        .rst       (rst),
        .push      (rd_ret_ok),
        .push_data (init_mem_rd_data),
        .pop       (rdata_vld && rdata_rdy),
        .pop_data  (rdata),
        .count     (fifo_count),
        .full      (fifo_full),
        .empty     (fifo_empty)
    );

endmodule

// File: tb/tb_global_mem_init_ctrl.sv
// Bench for global_mem_init_ctrl: directed bursts, a 3-cycle memory model,
// and a scoreboard monitor that checks every request beat and read word.
module tb_global_mem_init_ctrl;

    localparam int AW  = 16;
    localparam int DW  = 32;
    localparam int LW  = 16;
    localparam int DEP = 8;

    typedef struct {
        logic [AW-1:0] addr;
        logic          wr;
        logic [DW-1:0] data;
    } beat_t;

    logic          clk;
    logic          rst;
    logic          cmd_vld;
    logic          cmd_rdy;
    logic          cmd_wr;
    logic [AW-1:0] cmd_addr;
    logic [LW-1:0] cmd_len;
    logic          wdata_vld;
    logic          wdata_rdy;
    logic [DW-1:0] wdata;
    logic          rdata_vld;
    logic          rdata_rdy;
    logic [DW-1:0] rdata;
    logic [AW-1:0] init_mem_addr;
    logic          init_mem_vld;
    logic          init_mem_wr_en;
    logic [DW-1:0] init_mem_wr_data;
    logic [DW-1:0] init_mem_rd_data;
    logic          init_mem_rd_data_vld;
    logic          init_active;
    logic          done;
    logic          err;

    global_mem_init_ctrl #(
        .GLOBAL_MEM_ADDR_L (AW),
        .DATA_L            (DW),
        .LEN_L             (LW),
        .RD_FIFO_DEPTH     (DEP)
    ) dut (
        .clk                  (clk),
        .rst                  (rst),
        .cmd_vld              (cmd_vld),
        .cmd_rdy              (cmd_rdy),
        .cmd_wr               (cmd_wr),
        .cmd_addr             (cmd_addr),
        .cmd_len              (cmd_len),
        .wdata_vld            (wdata_vld),
        .wdata_rdy            (wdata_rdy),
        .wdata                (wdata),
        .rdata_vld            (rdata_vld),
        .rdata_rdy            (rdata_rdy),
        .rdata                (rdata),
        .init_mem_addr        (init_mem_addr),
        .init_mem_vld         (init_mem_vld),
        .init_mem_wr_en       (init_mem_wr_en),
        .init_mem_wr_data     (init_mem_wr_data),
        .init_mem_rd_data     (init_mem_rd_data),
        .init_mem_rd_data_vld (init_mem_rd_data_vld),
        .init_active          (init_active),
        .done                 (done),
        .err                  (err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // ---------------- memory model: 3-cycle read latency ----------------
    logic [DW-1:0] mem [0:65535];
    logic [2:0]    pv;
    logic [DW-1:0] pd0, pd1, pd2;
    logic          inj;
    logic [DW-1:0] inj_data;

    initial begin
        for (int i = 0; i < 65536; i++) mem[i] = 32'hC0DE_0000 | i;
    end

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            pv <= 3'b000;
        end else begin
            if (init_mem_vld && init_mem_wr_en) mem[init_mem_addr] <= init_mem_wr_data;
            pv  <= {pv[1:0], init_mem_vld && !init_mem_wr_en};
            pd0 <= mem[init_mem_addr];
            pd1 <= pd0;
            pd2 <= pd1;
        end
    end

    assign init_mem_rd_data_vld = pv[2] | inj;
    assign init_mem_rd_data     = inj ? inj_data : pd2;

    // ---------------- scoreboard ----------------
    int checks = 0;
    int errors = 0;

    beat_t         exp_beat[$];
    logic [DW-1:0] exp_rd[$];
    int            beat_cyc[$];
    int issue_cnt = 0;
    int pop_cnt   = 0;
    int done_cnt  = 0;
    int done_cyc  = 0;
    int ret_cyc   = 0;
    int ret_cnt   = 0;
    int exp_done  = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    beat_t         mb;
    logic [DW-1:0] mr;
    always @(negedge clk) begin
        if (!rst) begin
            if (init_mem_vld) begin
                issue_cnt++;
                beat_cyc.push_back(cyc);
                if (exp_beat.size() == 0) begin
                    chk("unexpected_beat", 1, 0);
                end else begin
                    mb = exp_beat.pop_front();
                    chk("beat_addr", init_mem_addr, mb.addr);
                    chk("beat_wr_en", init_mem_wr_en, mb.wr);
                    if (mb.wr) chk("beat_wr_data", init_mem_wr_data, mb.data);
                end
            end
            if (rdata_vld && rdata_rdy) begin
                pop_cnt++;
                if (exp_rd.size() == 0) begin
                    chk("unexpected_rdata", 1, 0);
                end else begin
                    mr = exp_rd.pop_front();
                    chk("rdata", rdata, mr);
                end
            end
            if (init_mem_rd_data_vld) begin
                ret_cnt++;
                ret_cyc = cyc;
            end
            if (done) begin
                done_cnt++;
                done_cyc = cyc;
            end
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic send_cmd(input logic wr, input logic [AW-1:0] a, input logic [LW-1:0] l);
        int t = 0;
        @(negedge clk);
        cmd_wr   = wr;
        cmd_addr = a;
        cmd_len  = l;
        cmd_vld  = 1'b1;
        while (!cmd_rdy && t < 100) begin
            @(negedge clk);
            t++;
        end
        if (t >= 100) chk("cmd_accept_timeout", 0, 1);
        @(posedge clk);
        #1 cmd_vld = 1'b0;
    endtask

    task automatic write_burst(input logic [AW-1:0] a, input logic [LW-1:0] l,
                               input logic [DW-1:0] d0);
        for (int i = 0; i <= int'(l); i++) begin
            exp_beat.push_back('{a + AW'(i), 1'b1, d0 + DW'(i)});
        end
        exp_done++;
        send_cmd(1'b1, a, l);
        for (int i = 0; i <= int'(l); i++) begin
            int t = 0;
            wdata_vld = 1'b1;
            wdata     = d0 + DW'(i);
            while (!wdata_rdy && t < 100) begin
                @(negedge clk);
                t++;
            end
            if (t >= 100) chk("wdata_timeout", 0, 1);
            @(posedge clk);
            #1;
        end
        wdata_vld = 1'b0;
    endtask

    task automatic read_burst(input logic [AW-1:0] a, input logic [LW-1:0] l,
                              input logic use_a, input logic [DW-1:0] d0);
        for (int i = 0; i <= int'(l); i++) begin
            logic [AW-1:0] ai;
            ai = a + AW'(i);
            exp_beat.push_back('{ai, 1'b0, '0});
            exp_rd.push_back(use_a ? (d0 + DW'(i)) : (32'hC0DE_0000 | DW'(ai)));
        end
        exp_done++;
        send_cmd(1'b0, a, l);
    endtask

    task automatic wait_done();
        int t = 0;
        while (done_cnt < exp_done && t < 300) begin
            @(negedge clk);
            t++;
        end
        chk("done_count", done_cnt, exp_done);
    endtask

    task automatic wait_rd_empty();
        int t = 0;
        while (exp_rd.size() != 0 && t < 300) begin
            @(negedge clk);
            t++;
        end
        chk("rd_queue_drained", exp_rd.size(), 0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got running expected finished");
        $fatal(1, "watchdog");
    end

    // ---------------- test sequence ----------------
    int iss0;
    int pop0;
    initial begin
        rst = 1'b1; cmd_vld = 0; cmd_wr = 0; cmd_addr = 0; cmd_len = 0;
        wdata_vld = 0; wdata = 0; rdata_rdy = 1; inj = 0; inj_data = 0;

        // Reset state
        repeat (3) @(negedge clk);
        chk("rst_cmd_rdy", cmd_rdy, 0);
        chk("rst_wdata_rdy", wdata_rdy, 0);
        chk("rst_rdata_vld", rdata_vld, 0);
        chk("rst_init_mem_vld", init_mem_vld, 0);
        chk("rst_wr_en", init_mem_wr_en, 0);
        chk("rst_addr", init_mem_addr, 0);
        chk("rst_wr_data", init_mem_wr_data, 0);
        chk("rst_init_active", init_active, 0);
        chk("rst_done", done, 0);
        chk("rst_err", err, 0);
        rst = 1'b0;
        @(negedge clk);
        chk("idle_cmd_rdy", cmd_rdy, 1);

        // Write burst 0x10..0x13, A0..A3
        beat_cyc.delete();
        write_burst(16'h0010, 16'd3, 32'hA0);
        wait_done();
        chk("wr_beats", beat_cyc.size(), 4);
        if (beat_cyc.size() == 4) begin
            chk("wr_consecutive", beat_cyc[3] - beat_cyc[0], 3);
            chk("wr_done_timing", done_cyc, beat_cyc[3] + 1);
        end

        // Read the same words back
        ret_cnt = 0;
        read_burst(16'h0010, 16'd3, 1'b1, 32'hA0);
        wait_done();
        wait_rd_empty();
        chk("rd_returns", ret_cnt, 4);
        chk("rd_done_after_last_return", done_cyc, ret_cyc + 2);
        chk("rd_err", err, 0);

        // Back-pressure: 16 reads with the host stalled
        rdata_rdy = 1'b0;
        iss0 = issue_cnt;
        pop0 = pop_cnt;
        read_burst(16'h0100, 16'd15, 1'b0, 32'h0);
        repeat (40) @(negedge clk);
        chk("bp_issued_stall", issue_cnt - iss0, 8);
        chk("bp_rdata_vld", rdata_vld, 1);
        chk("bp_no_done", done_cnt, exp_done - 1);
        chk("bp_active", init_active, 1);
        rdata_rdy = 1'b1;
        wait_done();
        wait_rd_empty();
        chk("bp_issued_total", issue_cnt - iss0, 16);
        chk("bp_popped_total", pop_cnt - pop0, 16);
        chk("bp_err", err, 0);

        // Address wrap
        beat_cyc.delete();
        write_burst(16'hFFFE, 16'd3, 32'hB0);
        wait_done();
        chk("wrap_beats", beat_cyc.size(), 4);

        // Asynchronous reset after the 2nd beat of a write burst
        exp_beat.push_back('{16'h0020, 1'b1, 32'hC1});
        send_cmd(1'b1, 16'h0020, 16'd7);
        chk("mid_wdata_rdy", wdata_rdy, 1);
        wdata_vld = 1'b1;
        wdata     = 32'hC1;
        @(posedge clk);
        #1 wdata = 32'hC2;
        @(posedge clk);
        #2;
        chk("mid_beat2_vld", init_mem_vld, 1);
        chk("mid_beat2_addr", init_mem_addr, 16'h0021);
        rst = 1'b1;
        wdata_vld = 1'b0;
        #1;
        chk("async_rst_vld", init_mem_vld, 0);
        chk("async_rst_active", init_active, 0);
        chk("async_rst_cmd_rdy", cmd_rdy, 0);
        #5 rst = 1'b0;
        exp_beat.delete();
        @(negedge clk);
        chk("post_rst_cmd_rdy", cmd_rdy, 1);
        chk("post_rst_active", init_active, 0);
        chk("post_rst_err", err, 0);
        inj_data = 32'hDEAD_BEEF;
        inj = 1'b1;
        @(negedge clk);
        inj = 1'b0;
        @(negedge clk);
        chk("stray_err", err, 1);
        chk("stray_no_rdata", rdata_vld, 0);
        repeat (3) @(negedge clk);
        chk("err_sticky", err, 1);

        chk("final_beats_left", exp_beat.size(), 0);
        chk("final_done_count", done_cnt, exp_done);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/global_mem_init_ctrl.md
# global_mem_init_ctrl

Host-side sequencer for the global-memory initialization port of the interconnect. It accepts burst commands (write N words from a stream, or read N words back into a stream). It drives init_mem_addr/vld/wr_en/wr_data one word per cycle and collects init_mem_rd_data into a small FIFO with host back-pressure. It asserts init_active for the whole burst, which the PE scheduler uses to hold off PE traffic.

## Interface
- GLOBAL_MEM_ADDR_L, default 16: global word address width.
- DATA_L, default 32: data word width.
- LEN_L, default 16: burst length field width.
- RD_FIFO_DEPTH, default 8: read-return FIFO depth; power of two, ≥2.
- clk  in  1  clock; all logic on posedge.
- rst  in  1  asynchronous, active-high reset.
- cmd_vld  in  1  command valid.
- cmd_rdy  out  1  command accepted when cmd_vld & cmd_rdy.
- cmd_wr  in  1  1 = write burst, 0 = read burst.
- cmd_addr  in  GLOBAL_MEM_ADDR_L  burst base word address.
- cmd_len  in  LEN_L  word count minus 1.
- wdata_vld  in  1  write-stream valid.
- wdata_rdy  out  1  write-stream ready.
- wdata  in  DATA_L  write word.
- rdata_vld  out  1  read-stream valid.
- rdata_rdy  in  1  read-stream ready.
- rdata  out  DATA_L  read word.
- init_mem_addr  out  GLOBAL_MEM_ADDR_L  to interconnect.
- init_mem_vld  out  1  to interconnect.
- init_mem_wr_en  out  1  to interconnect.
- init_mem_wr_data  out  DATA_L  to interconnect.
- init_mem_rd_data  in  DATA_L  from interconnect; in order.
- init_mem_rd_data_vld  in  1  from interconnect.
- init_active  out  1  high while state ≠ IDLE.
- done  out  1  one-cycle pulse at burst completion.
- err  out  1  sticky; set on unexpected read return; cleared only by rst.

## Operation
- States: IDLE, WRITE, READ, DRAIN.
- IDLE:
  - cmd_rdy=1.
  - On accept: latch base, len, and direction; clear beat counter k; go to WRITE if cmd_wr=1, else READ.
- WRITE:
  - wdata_rdy=1.
  - Each wdata handshake registers init_mem_vld=1, wr_en=1, addr=base+k, wr_data=wdata; then k++.
  - When k reaches len: go to DRAIN.
- READ: issue one read (init_mem_vld=1, wr_en=0, addr=base+k) in any cycle where outstanding + fifo_count < RD_FIFO_DEPTH. On the final issue, go to DRAIN.
- outstanding counter:
  - Incremented at the issue decision.
  - Decremented on init_mem_rd_data_vld.
  - Issue and return in the same cycle leave it unchanged.
  - Width is $clog2(RD_FIFO_DEPTH+1).
- Every init_mem_rd_data_vld pushes init_mem_rd_data into the FIFO. The FIFO can never overflow, because of the issue credit rule above.
- FIFO head drives rdata/rdata_vld and pops on rdata_vld & rdata_rdy.
- DRAIN:
  - Wait until outstanding==0; a write burst reaches this immediately.
  - Then pulse done and return to IDLE.
  - The FIFO may still hold words; the host drains them independently. A new command may be accepted while they remain.
- Address arithmetic: base+k is taken modulo 2^GLOBAL_MEM_ADDR_L, so bursts wrap past the top address.
- Unexpected return: init_mem_rd_data_vld with outstanding==0 is dropped (no FIFO push, counter stays 0) and sets err.
- init_mem_vld is 0 in every cycle without an issue. When it is 0, addr/wr_en/wr_data hold their last values.

## Timing
- Reset values: cmd_rdy=0 while rst is high, and 1 in IDLE afterwards. All other outputs are 0: wdata_rdy, rdata_vld, init_mem_vld, init_mem_wr_en, init_mem_addr, init_mem_wr_data, init_active, done, err.
- Command accepted at cycle T: state changes at T+1, and wdata_rdy / the first read issue are possible from T+1.
- Issue latency: a beat decided in cycle t (write handshake or read issue) appears on init_mem_* in cycle t+1. This gives one word per cycle sustained.
- done is asserted in the cycle after DRAIN sees outstanding==0.
- FIFO: a word pushed in cycle t is visible on rdata in cycle t+1. Simultaneous push and pop are allowed when full or empty.
- Asynchronous reset mid-burst:
  - init_mem_vld and init_active drop immediately, without waiting for a clock.
  - The FIFO and all counters clear, and in-flight reads are forgotten.
  - Returns arriving after reset set err.

## Structure
- interconnect_pkg gains:
  - init_ctrl_state_t enum {IDLE, WRITE, READ, DRAIN};
  - INIT_LEN_L;
  - INIT_RD_FIFO_DEPTH.
- One sub-module, init_rd_fifo: a parameterized synchronous FIFO with push/pop/count/full/empty, asynchronous active-high rst.
- The FSM, beat counter, outstanding counter and output registers sit in global_mem_init_ctrl.

## Test plan
- Write burst: cmd_wr=1, addr=0x0010, len=3, wdata 0xA0..0xA3 back-to-back. Required: init_mem_vld on 4 consecutive cycles, addrs 0x10..0x13, wr_en=1, then done one cycle later.
- Read burst with a 3-cycle memory model: read addr=0x0010, len=3, rdata_rdy=1. Required: rdata sequence 0xA0..0xA3 in order, done after the 4th return, err=0.
- Back-pressure: read len=15, RD_FIFO_DEPTH=8, rdata_rdy=0. Required: exactly 8 reads issued, then issue stalls; releasing rdata_rdy completes all 16 with no loss.
- Address wrap: write at addr=0xFFFE, len=3. Required: addrs 0xFFFE, 0xFFFF, 0x0000, 0x0001.
- Reset mid-burst: assert rst after the 2nd write beat. Required: init_mem_vld=0 with no clock edge, state IDLE, cmd_rdy=1 after release; a stray return afterwards sets err=1.
